fetch_queue: RTL and testbench
==============================

// Module: fetch_queue
// PURPOSE
//  Decoupled instruction-fetch front end between the branch predictor/instruction memory and the F/D pipeline register.
//  Issues in-order fetch requests on a valid/ready imem port. Buffers up to DEPTH instructions with their PC and prediction.
//  Hands them to decode under back-pressure (~stall). Discards wrong-path fetches on an execute-stage redirect.
// PARAMETERS
//  DEPTH     4         queue entries = max outstanding+buffered fetches; power of 2, >=2
//  RESET_PC  32'h0     first fetch address after reset
// PORTS
//  clk               in   1   clock, rising edge
//  rst               in   1   reset, asynchronous, active-low
//  redirect_valid    in   1   execute-stage mispredict; flush and restart
//  redirect_pc       in   32  corrected PC
//  bp_pc             out  32  PC presented to predictor lookup (= fetch_pc)
//  bp_pred_pc        in   32  predicted next PC for bp_pc (pc+4 when not taken)
//  bp_pred_taken     in   1   predictor taken flag for bp_pc
//  imem_req_valid    out  1   fetch request
//  imem_req_ready    in   1   imem accepts request
//  imem_req_addr     out  32  fetch address
//  imem_rsp_valid    in   1   instruction returned; in request order, >=1 cycle after accept
//  imem_rsp_data     in   32  instruction word
//  instr_valid       out  1   head entry holds a filled instruction
//  instr_ready       in   1   decode accepts (= ~stall)
//  instr_data        out  32  head instruction
//  instr_pc          out  32  head PC
//  instr_pred_pc     out  32  head predicted next PC
//  instr_pred_taken  out  1   head predicted-taken flag
// BEHAVIOUR
//  - Reset (rst=0): fetch_pc=RESET_PC; head/alloc/fill ptrs, count, pending, drop_cnt = 0; all entries invalid.
//    Outputs: imem_req_valid=0, instr_valid=0, instr_* = 0, imem_req_addr=RESET_PC.
//  - Allocation at issue: imem_req_valid = (count<DEPTH) & ~redirect_valid; imem_req_addr = fetch_pc.
//    On accept (valid&ready): entry[alloc] gets {pc=fetch_pc, pred_pc=bp_pred_pc, pred_taken=bp_pred_taken, filled=0}.
//    alloc++, count++, pending++, fetch_pc <= bp_pred_pc. Back-to-back accepts allowed: one per cycle.
//  - Fill: rsp_valid & drop_cnt==0 -> entry[fill].instr=rsp_data, filled=1, fill++, pending--.
//    rsp_valid & drop_cnt>0 -> response discarded, drop_cnt--.
//  - Dequeue: instr_valid = entry[head].filled & ~redirect_valid. instr_valid&instr_ready -> head++, count--.
//    The F/D register stays stalled while instr_valid=0.
//  - Simultaneous accept + dequeue in one cycle: count unchanged. Full (count==DEPTH): no request; dequeue frees a slot next cycle.
//  - Redirect (highest priority): all entries invalidated, pointers/count/pending=0, fetch_pc<=redirect_pc.
//    drop_cnt <= drop_cnt + pending - (rsp_valid ? 1 : 0).
//    In the redirect cycle: no request issued, no enqueue, no dequeue; an unaccepted request is withdrawn.
//    First request to redirect_pc is issued the next cycle.
//  - Pointers wrap modulo DEPTH; count, pending and drop_cnt are $clog2(DEPTH)+1 bits.
//    drop_cnt never exceeds DEPTH. pending<=count<=DEPTH always.
//  - Mid-operation reset: in-flight responses are not tracked; the imem is reset together with this block.
// CONFIGURATION
//  FETCH_QUEUE_BYPASS_EN defined:
//    If the head entry is unfilled, count>0 and a non-dropped response arrives, instr_valid=1 and instr_data=rsp_data in the same cycle.
//    If also instr_ready, the entry is consumed without ever being marked filled. Minimum rsp->decode latency 0 cycles.
//  Undefined: instr_valid comes only from the registered filled bit; minimum latency 1 cycle.
// STRUCTURE
//  fetch_pkg: XLEN=32, fq_entry_t struct {pc, pred_pc, pred_taken, instr, filled}, NOP_INSTR=32'h0000_0013.
//  Single module with an inline entry array plus head/alloc/fill pointer logic. No sub-module.
// TESTING
//  1. Reset release, 1-cycle imem, instr_ready=1, predictor returns pc+4 ->
//     requests 0x0,0x4,0x8...; instr_valid from cycle 2, one instr/cycle, instr_pc in order.
//  2. instr_ready=0 for 10 cycles ->
//     exactly 4 accepts then imem_req_valid=0; count=4; on instr_ready=1, issue resumes with 0x10.
//  3. 3-cycle imem latency, 3 requests pending, redirect_pc=0x100 ->
//     drop_cnt=3; the next 3 responses are discarded; first delivered instr_pc=0x100.
//  4. Redirect in the same cycle as a response with pending=2 ->
//     drop_cnt=1; no enqueue; next request is 0x100 one cycle later.
//  5. Predictor bp_pred_pc=0x40 for PC 0x8 ->
//     request sequence 0x8,0x40; entry for 0x8 carries pred_pc=0x40, pred_taken=1.
//  6. Bypass build, empty queue, response arrives ->
//     instr_valid same cycle, instr_data=rsp_data. Non-bypass build: instr_valid one cycle later.

Source files
------------

// File: rtl/fetch_pkg.sv
// Shared types and constants for the instruction-fetch queue.
package fetch_pkg;

    localparam int unsigned XLEN = 32;
    localparam logic [XLEN-1:0] NOP_INSTR = 32'h0000_0013;

    typedef struct packed {
        logic [XLEN-1:0] pc;
        logic [XLEN-1:0] pred_pc;
        logic            pred_taken;
        logic [XLEN-1:0] instr;
        logic            filled;
    } fq_entry_t;

endpackage

// File: rtl/fetch_queue.sv
// Decoupled fetch front end: in-order imem requests, DEPTH-entry buffer, redirect flush.
// Define FETCH_QUEUE_BYPASS_EN to forward a response straight to decode when the head is waiting.
module fetch_queue
    import fetch_pkg::*;
#(
    parameter int unsigned     DEPTH    = 4,
    parameter logic [XLEN-1:0] RESET_PC = 32'h0
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            redirect_valid,
    input  logic [XLEN-1:0] redirect_pc,
    output logic [XLEN-1:0] bp_pc,
    input  logic [XLEN-1:0] bp_pred_pc,
    input  logic            bp_pred_taken,
    output logic            imem_req_valid,
    input  logic            imem_req_ready,
    output logic [XLEN-1:0] imem_req_addr,
    input  logic            imem_rsp_valid,
    input  logic [XLEN-1:0] imem_rsp_data,
    output logic            instr_valid,
    input  logic            instr_ready,
    output logic [XLEN-1:0] instr_data,
    output logic [XLEN-1:0] instr_pc,
    output logic [XLEN-1:0] instr_pred_pc,
    output logic            instr_pred_taken
);

    localparam int unsigned PW = $clog2(DEPTH);
    localparam int unsigned CW = PW + 1;
    localparam logic [CW-1:0] DepthC = CW'(DEPTH);

    fq_entry_t       entries_q [DEPTH];
    fq_entry_t       entries_d [DEPTH];
    logic [PW-1:0]   head_q, head_d, alloc_q, alloc_d, fill_q, fill_d;
    logic [CW-1:0]   count_q, count_d, pending_q, pending_d, drop_cnt_q, drop_cnt_d;
    logic [XLEN-1:0] fetch_pc_q, fetch_pc_d;

    logic req_fire, rsp_fill, rsp_drop, head_filled, bypass_hit, deq_fire;

    always_comb begin
        // Request is held off during reset so nothing is issued before the imem is live.
        imem_req_valid = rst & ~redirect_valid & (count_q < DepthC);
        imem_req_addr  = fetch_pc_q;
        bp_pc          = fetch_pc_q;
        req_fire       = imem_req_valid & imem_req_ready;
        rsp_fill       = imem_rsp_valid & (drop_cnt_q == '0);
        rsp_drop       = imem_rsp_valid & (drop_cnt_q != '0);
        head_filled    = entries_q[head_q].filled;
`ifdef FETCH_QUEUE_BYPASS_EN
        // Head unfilled with count>0 means the fill pointer is at the head.
        bypass_hit     = ~head_filled & (count_q != '0) & rsp_fill & rst;
        instr_data     = bypass_hit ? imem_rsp_data : entries_q[head_q].instr;
`else
        bypass_hit     = 1'b0;
        instr_data     = entries_q[head_q].instr;
`endif
        instr_valid      = (head_filled | bypass_hit) & ~redirect_valid;
        instr_pc         = entries_q[head_q].pc;
        instr_pred_pc    = entries_q[head_q].pred_pc;
        instr_pred_taken = entries_q[head_q].pred_taken;
        deq_fire         = instr_valid & instr_ready;
    end

    always_comb begin
        entries_d  = entries_q;
        head_d     = head_q;
        alloc_d    = alloc_q;
        fill_d     = fill_q;
        count_d    = count_q;
        pending_d  = pending_q;
        drop_cnt_d = drop_cnt_q;
        fetch_pc_d = fetch_pc_q;
        if (redirect_valid) begin
            for (int unsigned i = 0; i < DEPTH; i++) begin
                entries_d[i].filled = 1'b0;
            end
            head_d     = '0;
            alloc_d    = '0;
            fill_d     = '0;
            count_d    = '0;
            pending_d  = '0;
            fetch_pc_d = redirect_pc;
            drop_cnt_d = drop_cnt_q + pending_q - CW'(imem_rsp_valid);
        end else begin
            if (req_fire) begin
                entries_d[alloc_q].pc         = fetch_pc_q;
                entries_d[alloc_q].pred_pc    = bp_pred_pc;
                entries_d[alloc_q].pred_taken = bp_pred_taken;
                entries_d[alloc_q].instr      = NOP_INSTR;
                entries_d[alloc_q].filled     = 1'b0;
                alloc_d    = alloc_q + PW'(1);
                fetch_pc_d = bp_pred_pc;
            end
            if (rsp_drop) begin
                drop_cnt_d = drop_cnt_q - CW'(1);
            end
            if (rsp_fill) begin
                entries_d[fill_q].instr  = imem_rsp_data;
                entries_d[fill_q].filled = 1'b1;
                fill_d = fill_q + PW'(1);
            end
            // Clearing after the fill lets a bypassed entry leave without staying filled.
            if (deq_fire) begin
                entries_d[head_q].filled = 1'b0;
                head_d = head_q + PW'(1);
            end
            count_d   = count_q + CW'(req_fire) - CW'(deq_fire);
            pending_d = pending_q + CW'(req_fire) - CW'(rsp_fill);
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int unsigned i = 0; i < DEPTH; i++) begin
                entries_q[i] <= '0;
            end
            head_q     <= '0;
            alloc_q    <= '0;
            fill_q     <= '0;
            count_q    <= '0;
            pending_q  <= '0;
            drop_cnt_q <= '0;
            fetch_pc_q <= RESET_PC;
        end else begin
            entries_q  <= entries_d;
            head_q     <= head_d;
            alloc_q    <= alloc_d;
            fill_q     <= fill_d;
            count_q    <= count_d;
            pending_q  <= pending_d;
            drop_cnt_q <= drop_cnt_d;
            fetch_pc_q <= fetch_pc_d;
        end
    end

endmodule

// File: tb/tb_fetch_queue.sv
// Scoreboard bench for fetch_queue: the expected instruction stream follows the predictor from the
// last redirect; an in-order imem model with random latency feeds the DUT.
module tb_fetch_queue;
    import fetch_pkg::*;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        redirect_valid, imem_req_ready, imem_rsp_valid, instr_ready;
    logic [31:0] redirect_pc, imem_rsp_data, bp_pred_pc;
    logic        bp_pred_taken;
    logic [31:0] bp_pc, imem_req_addr, instr_data, instr_pc, instr_pred_pc;
    logic        imem_req_valid, instr_valid, instr_pred_taken;

    typedef struct {
        logic [31:0] pc;
        logic [31:0] pred_pc;
        logic [31:0] instr;
        logic        taken;
    } exp_t;
    typedef struct {
        logic [31:0] addr;
        int unsigned due;
    } mreq_t;

    exp_t  exp_q[$];
    mreq_t mem_q[$];

    int unsigned n_checks = 0, n_fail = 0, cyc = 0, n_deq = 0;
    int unsigned k_ready_pct = 100, k_mrdy_pct = 100, k_redir_pct = 0;
    int unsigned k_lat_min = 1, k_lat_max = 1;
    logic        k_rand_pred = 1'b0;
    logic        force_redir = 1'b0;
    logic [31:0] force_pc = '0;
    logic [31:0] req_pc = '0;
    logic [31:0] first_pc = '0;
    logic        wait_first = 1'b0, got_first = 1'b0;

    fetch_queue #(.DEPTH(4), .RESET_PC(32'h0)) dut (
        .clk              (clk),
        .rst              (rst),
        .redirect_valid   (redirect_valid),
        .redirect_pc      (redirect_pc),
        .bp_pc            (bp_pc),
        .bp_pred_pc       (bp_pred_pc),
        .bp_pred_taken    (bp_pred_taken),
        .imem_req_valid   (imem_req_valid),
        .imem_req_ready   (imem_req_ready),
        .imem_req_addr    (imem_req_addr),
        .imem_rsp_valid   (imem_rsp_valid),
        .imem_rsp_data    (imem_rsp_data),
        .instr_valid      (instr_valid),
        .instr_ready      (instr_ready),
        .instr_data       (instr_data),
        .instr_pc         (instr_pc),
        .instr_pred_pc    (instr_pred_pc),
        .instr_pred_taken (instr_pred_taken)
    );

    initial forever #5 clk = ~clk;

    function automatic logic pred_taken_of(input logic [31:0] pc, input logic rnd);
        return (pc == 32'h8) || (rnd && pc[4:2] == 3'b101);
    endfunction

    function automatic logic [31:0] pred_pc_of(input logic [31:0] pc, input logic rnd);
        if (pc == 32'h8) return 32'h40;
        if (pred_taken_of(pc, rnd)) return (pc ^ 32'h120) & 32'hFFFF_FFFC;
        return pc + 32'd4;
    endfunction

    function automatic logic [31:0] mem_of(input logic [31:0] a);
        return {a[15:0], ~a[31:16]} ^ 32'h5A5A_1234;
    endfunction

    assign bp_pred_pc    = pred_pc_of(bp_pc, k_rand_pred);
    assign bp_pred_taken = pred_taken_of(bp_pc, k_rand_pred);

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp_v);
        n_checks++;
        if (act !== exp_v) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp_v, cyc);
        end
    endtask

    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #3;
    endtask

    // Stimulus driver and in-order imem model.
    initial begin
        redirect_valid = 1'b0;
        redirect_pc    = '0;
        imem_req_ready = 1'b0;
        imem_rsp_valid = 1'b0;
        imem_rsp_data  = '0;
        instr_ready    = 1'b0;
        forever begin
            @(posedge clk);
            cyc++;
            #1;
            if (mem_q.size() > 0 && mem_q[0].due <= cyc) begin
                imem_rsp_valid = 1'b1;
                imem_rsp_data  = mem_of(mem_q[0].addr);
                void'(mem_q.pop_front());
            end else begin
                imem_rsp_valid = 1'b0;
                imem_rsp_data  = $urandom;
            end
            instr_ready    = ($urandom_range(99) < k_ready_pct);
            imem_req_ready = ($urandom_range(99) < k_mrdy_pct);
            if (force_redir) begin
                redirect_valid = 1'b1;
                redirect_pc    = force_pc;
                force_redir    = 1'b0;
            end else if (rst && $urandom_range(99) < k_redir_pct) begin
                redirect_valid = 1'b1;
                redirect_pc    = $urandom & 32'h0000_0FFC;
            end else begin
                redirect_valid = 1'b0;
            end
        end
    end

    // Monitor: checks handshakes against the reference stream and pops the scoreboard.
    initial forever begin
        @(negedge clk);
        if (rst) begin
            chk("req_valid", 32'(imem_req_valid), 32'((exp_q.size() < 4) && !redirect_valid));
            chk("req_addr", imem_req_addr, req_pc);
            chk("bp_pc", bp_pc, req_pc);
            if (imem_req_valid && imem_req_ready)
                mem_q.push_back('{addr: imem_req_addr,
                                  due: cyc + $urandom_range(k_lat_max, k_lat_min)});
            if (redirect_valid) begin
                chk("instr_valid_in_redirect", 32'(instr_valid), 32'd0);
                exp_q.delete();
                req_pc     = redirect_pc;
                wait_first = 1'b1;
            end else begin
                if (instr_valid)
                    chk("valid_with_empty_queue", 32'(exp_q.size() != 0), 32'd1);
                if (instr_valid && instr_ready && exp_q.size() != 0) begin
                    exp_t e;
                    e = exp_q.pop_front();
                    n_deq++;
                    chk("instr_pc", instr_pc, e.pc);
                    chk("instr_pred_pc", instr_pred_pc, e.pred_pc);
                    chk("instr_pred_taken", 32'(instr_pred_taken), 32'(e.taken));
                    chk("instr_data", instr_data, e.instr);
                    if (wait_first) begin
                        first_pc   = instr_pc;
                        got_first  = 1'b1;
                        wait_first = 1'b0;
                    end
                end
                if (imem_req_valid && imem_req_ready) begin
                    exp_q.push_back('{pc: req_pc, pred_pc: pred_pc_of(req_pc, k_rand_pred),
                                      instr: mem_of(req_pc),
                                      taken: pred_taken_of(req_pc, k_rand_pred)});
                    req_pc = pred_pc_of(req_pc, k_rand_pred);
                end
            end
        end
    end

    initial begin
        int unsigned first_valid;
        int unsigned n0;
        step(3);
        chk("rst_req_valid", 32'(imem_req_valid), 32'd0);
        chk("rst_instr_valid", 32'(instr_valid), 32'd0);
        chk("rst_instr_data", instr_data, 32'd0);
        chk("rst_instr_pc", instr_pc, 32'd0);
        chk("rst_instr_pred_pc", instr_pred_pc, 32'd0);
        chk("rst_instr_pred_taken", 32'(instr_pred_taken), 32'd0);
        chk("rst_req_addr", imem_req_addr, 32'd0);

        // First delivery latency with a 1-cycle imem.
        rst = 1'b1;
        first_valid = 0;
        for (int i = 1; i <= 6; i++) begin
            step(1);
            if (instr_valid && first_valid == 0) first_valid = i;
        end
`ifdef FETCH_QUEUE_BYPASS_EN
        chk("first_valid_cycle", first_valid, 32'd1);
`else
        chk("first_valid_cycle", first_valid, 32'd2);
`endif
        step(10);

        // Decode stalled: the queue fills to DEPTH and issue stops.
        k_ready_pct = 0;
        step(12);
        chk("stall_req_valid", 32'(imem_req_valid), 32'd0);
        chk("stall_instr_valid", 32'(instr_valid), 32'd1);
        chk("stall_occupancy", exp_q.size(), 32'd4);
        if (exp_q.size() != 0) chk("stall_head_pc", instr_pc, exp_q[0].pc);
        k_ready_pct = 100;
        step(10);

        // Redirect with responses in flight on a 3-cycle imem.
        k_lat_min   = 3;
        k_lat_max   = 3;
        step(8);
        got_first   = 1'b0;
        force_pc    = 32'h100;
        force_redir = 1'b1;
        for (int i = 0; i < 60 && !got_first; i++) step(1);
        chk("redirect_first_pc", got_first ? first_pc : 32'hDEAD_BEEF, 32'h100);

        // Random traffic with redirects colliding with responses and stalls.
        k_rand_pred = 1'b1;
        k_lat_min   = 1;
        k_lat_max   = 3;
        k_ready_pct = 70;
        k_mrdy_pct  = 70;
        k_redir_pct = 3;
        step(3000);

        // Drain to steady state and check throughput recovers.
        k_redir_pct = 0;
        k_ready_pct = 100;
        k_mrdy_pct  = 100;
        k_lat_min   = 1;
        k_lat_max   = 1;
        step(20);
        n0 = n_deq;
        step(100);
        chk("steady_throughput", 32'((n_deq - n0) >= 50), 32'd1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
